// File: rtl/sblk_row_sched.sv
// sblk_row_sched
// Scheduler in front of sblk_row, clk_l domain.
//  - Instruction path: one 1-deep slot per row. A slot is filled from the host
//    stream and issued to its row as a one-cycle inst_en pulse once the row is
//    idle and its post-issue guard window has expired.
//  - Activation path: a two-state round-robin arbiter shares one source beat
//    stream among the rows' act_data_in_req requesters, in bursts of up to BURST beats.
// Ports:
//   clk_l, rst_n                      clock, async active-low reset
//   host_inst_data/row/vld, host_inst_rdy   host instruction stream (rdy is combinational)
//   inst_data, inst_en                per-row issued instruction and issue pulse
//   status_sblk                       per-row busy flag
//   src_act_data/vld, src_act_rdy     shared activation source
//   act_data_in, act_data_in_vld      per-row activation beat and beat valid
//   act_data_in_req                   per-row activation request
//   all_idle                          scheduler and rows quiescent (combinational)
module sblk_row_sched #(
   parameter int N_ROW    = 4,
   parameter int WID_ROW  = 2,
   parameter int WID_ACT  = 16,
   parameter int WID_INST = 14,
   parameter int BURST    = 8,
   parameter int GUARD    = 2
) (
   input  logic                        clk_l,
   input  logic                        rst_n,
   input  logic [WID_INST-1:0]         host_inst_data,
   input  logic [WID_ROW-1:0]          host_inst_row,
   input  logic                        host_inst_vld,
   output logic                        host_inst_rdy,
   output logic [WID_INST*N_ROW-1:0]   inst_data,
   output logic [N_ROW-1:0]            inst_en,
   input  logic [N_ROW-1:0]            status_sblk,
   input  logic [2*WID_ACT-1:0]        src_act_data,
   input  logic                        src_act_vld,
   output logic                        src_act_rdy,
   output logic [2*WID_ACT*N_ROW-1:0]  act_data_in,
   output logic [N_ROW-1:0]            act_data_in_vld,
   input  logic [N_ROW-1:0]            act_data_in_req,
   output logic                        all_idle
);

   localparam int WID_GRD  = (GUARD < 1) ? 1 : $clog2(GUARD + 1);
   localparam int WID_CNT  = (BURST < 2) ? 1 : $clog2(BURST);
   localparam int WID_BEAT = 2 * WID_ACT;
   localparam int WID_SUM  = WID_ROW + 1;
   localparam logic [WID_CNT-1:0] CNT_LAST = WID_CNT'(BURST - 1);
   localparam logic [WID_GRD-1:0] GRD_LOAD = WID_GRD'(GUARD);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_GRANT = 1'b1} arb_state_t;

   // instruction path
   logic [N_ROW-1:0]    full_r;
   logic [WID_INST-1:0] slot_r  [N_ROW];
   logic [WID_INST-1:0] inst_r  [N_ROW];
   logic [WID_GRD-1:0]  guard_r [N_ROW];
   logic [N_ROW-1:0]    inst_en_r;
   logic [N_ROW-1:0]    accept_s;
   logic [N_ROW-1:0]    issue_s;
   logic                guards_zero_s;

   // activation arbiter
   arb_state_t          state_r;
   arb_state_t          state_nxt_s;
   logic [WID_ROW-1:0]  g_r;
   logic [WID_ROW-1:0]  ptr_r;
   logic [WID_CNT-1:0]  cnt_r;
   logic [WID_ROW-1:0]  pick_s;
   logic                found_s;
   logic [WID_SUM-1:0]  sum_s;
   logic                beat_s;
   logic                release_s;
   logic [WID_BEAT-1:0] act_r [N_ROW];
   logic [N_ROW-1:0]    vld_r;

   assign host_inst_rdy = ~full_r[host_inst_row];

   // Per-row accept and issue qualifiers plus guard summary.
   always_comb begin
      accept_s      = {N_ROW{1'b0}};
      issue_s       = {N_ROW{1'b0}};
      guards_zero_s = 1'b1;
      for (int r = 0; r < N_ROW; r++) begin
         accept_s[r] = host_inst_vld & ~full_r[r] & (host_inst_row == WID_ROW'(r));
         issue_s[r]  = full_r[r] & ~status_sblk[r] & (guard_r[r] == {WID_GRD{1'b0}});
         if (guard_r[r] != {WID_GRD{1'b0}}) begin
            guards_zero_s = 1'b0;
         end else begin
            guards_zero_s = guards_zero_s;
         end
      end
   end

   // Slot fill, issue pulse, held issued word and guard countdown per row.
   always_ff @(posedge clk_l or negedge rst_n) begin
      if (!rst_n) begin
         full_r    <= {N_ROW{1'b0}};
         inst_en_r <= {N_ROW{1'b0}};
         for (int r = 0; r < N_ROW; r++) begin
            slot_r[r]  <= {WID_INST{1'b0}};
            inst_r[r]  <= {WID_INST{1'b0}};
            guard_r[r] <= {WID_GRD{1'b0}};
         end
      end else begin
         for (int r = 0; r < N_ROW; r++) begin
            if (issue_s[r]) begin
               // accept cannot coincide: the slot is full, so rdy is low
               full_r[r]    <= 1'b0;
               inst_en_r[r] <= 1'b1;
               inst_r[r]    <= slot_r[r];
               guard_r[r]   <= GRD_LOAD;
            end else begin
               inst_en_r[r] <= 1'b0;
               if (accept_s[r]) begin
                  full_r[r] <= 1'b1;
                  slot_r[r] <= host_inst_data;
               end
               if (guard_r[r] != {WID_GRD{1'b0}}) begin
                  guard_r[r] <= guard_r[r] - WID_GRD'(1);
               end
            end
         end
      end
   end

   // Round-robin pick: first requester at or after ptr, circularly.
   always_comb begin
      pick_s  = {WID_ROW{1'b0}};
      found_s = 1'b0;
      sum_s   = {WID_SUM{1'b0}};
      for (int i = 0; i < N_ROW; i++) begin
         sum_s = {1'b0, ptr_r} + WID_SUM'(i);
         if (sum_s >= WID_SUM'(N_ROW)) begin
            sum_s = sum_s - WID_SUM'(N_ROW);
         end else begin
            sum_s = sum_s;
         end
         if (!found_s && act_data_in_req[sum_s[WID_ROW-1:0]]) begin
            found_s = 1'b1;
            pick_s  = sum_s[WID_ROW-1:0];
         end else begin
            found_s = found_s;
         end
      end
   end

   // Arbiter state register.
   always_ff @(posedge clk_l or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Arbiter next-state: grant on any request, release on burst end or dropped request.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (|act_data_in_req) begin
               state_nxt_s = ST_GRANT;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_GRANT: begin
            if (release_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_GRANT;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Arbiter outputs: source ready only while the granted row keeps requesting.
   always_comb begin
      src_act_rdy = 1'b0;
      release_s   = 1'b0;
      beat_s      = 1'b0;
      if (state_r == ST_GRANT) begin
         src_act_rdy = act_data_in_req[g_r];
         release_s   = ~act_data_in_req[g_r] |
                       (src_act_vld & act_data_in_req[g_r] & (cnt_r == CNT_LAST));
      end else begin
         src_act_rdy = 1'b0;
         release_s   = 1'b0;
      end
      beat_s = src_act_vld & src_act_rdy;
   end

   // Grant index, rotation pointer and per-grant beat count.
   always_ff @(posedge clk_l or negedge rst_n) begin
      if (!rst_n) begin
         g_r   <= {WID_ROW{1'b0}};
         ptr_r <= {WID_ROW{1'b0}};
         cnt_r <= {WID_CNT{1'b0}};
      end else begin
         if (state_r == ST_IDLE) begin
            if (found_s) begin
               g_r <= pick_s;
            end
            cnt_r <= {WID_CNT{1'b0}};
         end else begin
            if (beat_s) begin
               cnt_r <= cnt_r + WID_CNT'(1);
            end
            if (release_s) begin
               // next search starts just past the row that was served
               ptr_r <= (g_r == WID_ROW'(N_ROW - 1)) ? {WID_ROW{1'b0}} : (g_r + WID_ROW'(1));
            end
         end
      end
   end

   // Beat capture into the granted row's slice; valid is a one-cycle one-hot pulse.
   always_ff @(posedge clk_l or negedge rst_n) begin
      if (!rst_n) begin
         vld_r <= {N_ROW{1'b0}};
         for (int r = 0; r < N_ROW; r++) begin
            act_r[r] <= {WID_BEAT{1'b0}};
         end
      end else begin
         if (beat_s) begin
            act_r[g_r] <= src_act_data;
            vld_r      <= {{(N_ROW-1){1'b0}}, 1'b1} << g_r;
         end else begin
            vld_r <= {N_ROW{1'b0}};
         end
      end
   end

   for (genvar r = 0; r < N_ROW; r++) begin : g_out
      assign inst_data[r*WID_INST +: WID_INST]   = inst_r[r];
      assign act_data_in[r*WID_BEAT +: WID_BEAT] = act_r[r];
   end

   assign inst_en         = inst_en_r;
   assign act_data_in_vld = vld_r;
   assign all_idle        = ~|full_r & ~|status_sblk & guards_zero_s & (state_r == ST_IDLE);

endmodule

// File: tb/tb_sblk_row_sched.sv
// Directed self-checking bench for sblk_row_sched (N_ROW=4, BURST=8, GUARD=2).
module tb_sblk_row_sched;

   logic          clk_l = 1'b0;
   logic          rst_n = 1'b1;
   logic [13:0]   host_inst_data = 14'h0;
   logic [1:0]    host_inst_row = 2'd0;
   logic          host_inst_vld = 1'b0;
   logic          host_inst_rdy;
   logic [55:0]   inst_data;
   logic [3:0]    inst_en;
   logic [3:0]    status_sblk = 4'h0;
   logic [31:0]   src_act_data = 32'h0;
   logic          src_act_vld = 1'b0;
   logic          src_act_rdy;
   logic [127:0]  act_data_in;
   logic [3:0]    act_data_in_vld;
   logic [3:0]    act_data_in_req = 4'h0;
   logic          all_idle;

   int vec_cnt = 0;
   int err_cnt = 0;

   sblk_row_sched #(.N_ROW(4), .WID_ROW(2), .WID_ACT(16), .WID_INST(14), .BURST(8), .GUARD(2)) dut (
      .clk_l(clk_l), .rst_n(rst_n),
      .host_inst_data(host_inst_data), .host_inst_row(host_inst_row),
      .host_inst_vld(host_inst_vld), .host_inst_rdy(host_inst_rdy),
      .inst_data(inst_data), .inst_en(inst_en), .status_sblk(status_sblk),
      .src_act_data(src_act_data), .src_act_vld(src_act_vld), .src_act_rdy(src_act_rdy),
      .act_data_in(act_data_in), .act_data_in_vld(act_data_in_vld),
      .act_data_in_req(act_data_in_req), .all_idle(all_idle)
   );

   always #5 clk_l = ~clk_l;

   task automatic tick;
      @(posedge clk_l);
      #1;
   endtask

   task automatic test_reset;
      #1 rst_n = 1'b0;
      #2;
      vec_cnt++; if (inst_en !== 4'h0) begin err_cnt++; $display("FAIL rst_inst_en got %b want 0000", inst_en); end
      vec_cnt++; if (inst_data !== 56'h0) begin err_cnt++; $display("FAIL rst_inst_data got %h want 0", inst_data); end
      vec_cnt++; if (act_data_in !== 128'h0) begin err_cnt++; $display("FAIL rst_act_data got %h want 0", act_data_in); end
      vec_cnt++; if (act_data_in_vld !== 4'h0) begin err_cnt++; $display("FAIL rst_act_vld got %b want 0000", act_data_in_vld); end
      vec_cnt++; if (src_act_rdy !== 1'b0) begin err_cnt++; $display("FAIL rst_src_rdy got %b want 0", src_act_rdy); end
      vec_cnt++; if (host_inst_rdy !== 1'b1) begin err_cnt++; $display("FAIL rst_host_rdy got %b want 1", host_inst_rdy); end
      repeat (2) @(posedge clk_l);
      #2 rst_n = 1'b1;
      tick();
      vec_cnt++; if (all_idle !== 1'b1) begin err_cnt++; $display("FAIL rst_all_idle got %b want 1", all_idle); end
   endtask

   task automatic test_issue;
      host_inst_row = 2'd2; host_inst_data = 14'h1A5; host_inst_vld = 1'b1;
      #1;
      vec_cnt++; if (host_inst_rdy !== 1'b1) begin err_cnt++; $display("FAIL issue_rdy got %b want 1", host_inst_rdy); end
      tick();                       // accept edge ends cycle T
      host_inst_vld = 1'b0;
      vec_cnt++; if (inst_en !== 4'h0) begin err_cnt++; $display("FAIL issue_en_t1 got %b want 0000", inst_en); end
      tick();                       // T+2
      vec_cnt++; if (inst_en !== 4'b0100) begin err_cnt++; $display("FAIL issue_en_t2 got %b want 0100", inst_en); end
      vec_cnt++; if (inst_data[28 +: 14] !== 14'h1A5) begin err_cnt++; $display("FAIL issue_data got %h want 1a5", inst_data[28 +: 14]); end
      vec_cnt++; if (all_idle !== 1'b0) begin err_cnt++; $display("FAIL issue_idle_t2 got %b want 0", all_idle); end
      tick();                       // T+3, guard 1
      vec_cnt++; if (inst_en !== 4'h0) begin err_cnt++; $display("FAIL issue_en_t3 got %b want 0000", inst_en); end
      vec_cnt++; if (inst_data[28 +: 14] !== 14'h1A5) begin err_cnt++; $display("FAIL issue_data_hold got %h want 1a5", inst_data[28 +: 14]); end
      vec_cnt++; if (all_idle !== 1'b0) begin err_cnt++; $display("FAIL issue_idle_t3 got %b want 0", all_idle); end
      tick();                       // T+4, guard 0
      vec_cnt++; if (all_idle !== 1'b1) begin err_cnt++; $display("FAIL issue_idle_t4 got %b want 1", all_idle); end
   endtask

   task automatic test_guard;
      logic [3:0] exp_en;
      status_sblk = 4'b0010;
      host_inst_row = 2'd1; host_inst_data = 14'h0AA; host_inst_vld = 1'b1;
      #1;
      vec_cnt++; if (host_inst_rdy !== 1'b1) begin err_cnt++; $display("FAIL guard_rdy_first got %b want 1", host_inst_rdy); end
      tick();
      host_inst_data = 14'h155;
      #1;
      vec_cnt++; if (host_inst_rdy !== 1'b0) begin err_cnt++; $display("FAIL guard_rdy_second got %b want 0", host_inst_rdy); end
      host_inst_vld = 1'b0; host_inst_row = 2'd3;
      #1;
      vec_cnt++; if (host_inst_rdy !== 1'b1) begin err_cnt++; $display("FAIL guard_rdy_other_row got %b want 1", host_inst_rdy); end
      host_inst_row = 2'd1; host_inst_vld = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         vec_cnt++; if (inst_en !== 4'h0) begin err_cnt++; $display("FAIL guard_busy_en cyc %0d got %b want 0000", i, inst_en); end
         vec_cnt++; if (host_inst_rdy !== 1'b0) begin err_cnt++; $display("FAIL guard_busy_rdy cyc %0d got %b want 0", i, host_inst_rdy); end
      end
      status_sblk = 4'h0;           // cycle d
      for (int j = 1; j <= 5; j++) begin
         tick();                    // cycle d+j
         if (j == 2) host_inst_vld = 1'b0;
         exp_en = (j == 1 || j == 4) ? 4'b0010 : 4'b0000;
         vec_cnt++; if (inst_en !== exp_en) begin err_cnt++; $display("FAIL guard_en d+%0d got %b want %b", j, inst_en, exp_en); end
         if (j == 1) begin
            vec_cnt++; if (inst_data[14 +: 14] !== 14'h0AA) begin err_cnt++; $display("FAIL guard_data_first got %h want 0aa", inst_data[14 +: 14]); end
            vec_cnt++; if (host_inst_rdy !== 1'b1) begin err_cnt++; $display("FAIL guard_rdy_after_issue got %b want 1", host_inst_rdy); end
         end
         if (j == 4) begin
            vec_cnt++; if (inst_data[14 +: 14] !== 14'h155) begin err_cnt++; $display("FAIL guard_data_second got %h want 155", inst_data[14 +: 14]); end
         end
      end
   endtask

   task automatic test_rr;
      logic [3:0] exp_v;
      int j;
      int gi;
      act_data_in_req = 4'hF; src_act_vld = 1'b1;
      for (int k = 0; k < 46; k++) begin
         src_act_data = 32'hC0DE_0000 + 32'(k);
         #1;
         exp_v = 4'h0; gi = 0;
         if (k >= 2) begin
            j = k - 2;
            gi = (j / 9) % 4;
            if ((j % 9) < 8) exp_v = 4'b0001 << gi;
         end
         vec_cnt++; if (act_data_in_vld !== exp_v) begin err_cnt++; $display("FAIL rr_vld k=%0d got %b want %b", k, act_data_in_vld, exp_v); end
         if (exp_v != 4'h0) begin
            vec_cnt++;
            if (act_data_in[gi*32 +: 32] !== 32'hC0DE_0000 + 32'(k - 1)) begin
               err_cnt++; $display("FAIL rr_data k=%0d got %h want %h", k, act_data_in[gi*32 +: 32], 32'hC0DE_0000 + 32'(k - 1));
            end
         end
         if (k == 0) begin
            vec_cnt++; if (src_act_rdy !== 1'b0) begin err_cnt++; $display("FAIL rr_idle_rdy got %b want 0", src_act_rdy); end
         end
         tick();
      end
      act_data_in_req = 4'h0; src_act_vld = 1'b0;
      tick();
      vec_cnt++; if (act_data_in_vld !== 4'h0) begin err_cnt++; $display("FAIL rr_end_vld got %b want 0000", act_data_in_vld); end
      vec_cnt++; if (all_idle !== 1'b1) begin err_cnt++; $display("FAIL rr_end_idle got %b want 1", all_idle); end
   endtask

   task automatic test_req_drop;
      logic [3:0] exp_v;
      int pulses0;
      pulses0 = 0;
      src_act_vld = 1'b1;
      for (int k = 0; k < 10; k++) begin
         act_data_in_req = (k <= 3) ? 4'b0001 : ((k == 5 || k == 6) ? 4'b1001 : 4'b0000);
         src_act_data = 32'hBEEF_0000 + 32'(k);
         #1;
         exp_v = (k >= 2 && k <= 4) ? 4'b0001 : ((k == 7) ? 4'b1000 : 4'b0000);
         vec_cnt++; if (act_data_in_vld !== exp_v) begin err_cnt++; $display("FAIL drop_vld k=%0d got %b want %b", k, act_data_in_vld, exp_v); end
         if (exp_v[0]) begin
            vec_cnt++; if (act_data_in[31:0] !== 32'hBEEF_0000 + 32'(k - 1)) begin err_cnt++; $display("FAIL drop_data0 k=%0d got %h want %h", k, act_data_in[31:0], 32'hBEEF_0000 + 32'(k - 1)); end
         end
         if (exp_v[3]) begin
            vec_cnt++; if (act_data_in[127:96] !== 32'hBEEF_0000 + 32'(k - 1)) begin err_cnt++; $display("FAIL drop_data3 k=%0d got %h want %h", k, act_data_in[127:96], 32'hBEEF_0000 + 32'(k - 1)); end
         end
         if (act_data_in_vld[0]) pulses0++;
         tick();
      end
      act_data_in_req = 4'h0; src_act_vld = 1'b0;
      vec_cnt++; if (pulses0 != 3) begin err_cnt++; $display("FAIL drop_pulse_count got %0d want 3", pulses0); end
      vec_cnt++; if (all_idle !== 1'b1) begin err_cnt++; $display("FAIL drop_idle got %b want 1", all_idle); end
   endtask

   task automatic test_vld_toggle;
      logic [3:0] exp_v;
      act_data_in_req = 4'b0100;
      for (int k = 0; k < 19; k++) begin
         src_act_vld = (k % 2 == 1);
         src_act_data = 32'h5A00_0000 + 32'(k);
         #1;
         exp_v = ((k >= 2 && k <= 16 && (k % 2 == 0)) || k == 18) ? 4'b0100 : 4'b0000;
         vec_cnt++; if (act_data_in_vld !== exp_v) begin err_cnt++; $display("FAIL tog_vld k=%0d got %b want %b", k, act_data_in_vld, exp_v); end
         if (exp_v != 4'h0) begin
            vec_cnt++; if (act_data_in[64 +: 32] !== 32'h5A00_0000 + 32'(k - 1)) begin err_cnt++; $display("FAIL tog_data k=%0d got %h want %h", k, act_data_in[64 +: 32], 32'h5A00_0000 + 32'(k - 1)); end
         end
         tick();
      end
      act_data_in_req = 4'h0; src_act_vld = 1'b0;
      tick();
      vec_cnt++; if (all_idle !== 1'b1) begin err_cnt++; $display("FAIL tog_idle got %b want 1", all_idle); end
   endtask

   task automatic test_reset_mid;
      status_sblk = 4'b1000;
      host_inst_row = 2'd3; host_inst_data = 14'h2222; host_inst_vld = 1'b1;
      act_data_in_req = 4'b0001; src_act_vld = 1'b1;
      for (int k = 0; k < 4; k++) begin
         src_act_data = 32'h7777_0000 + 32'(k);
         tick();
         host_inst_vld = 1'b0;
      end
      src_act_data = 32'h7777_0004;
      #1;
      vec_cnt++; if (act_data_in_vld !== 4'b0001) begin err_cnt++; $display("FAIL mid_pre_vld got %b want 0001", act_data_in_vld); end
      vec_cnt++; if (act_data_in[31:0] !== 32'h7777_0003) begin err_cnt++; $display("FAIL mid_pre_data got %h want 77770003", act_data_in[31:0]); end
      vec_cnt++; if (host_inst_rdy !== 1'b0) begin err_cnt++; $display("FAIL mid_pre_full got %b want 0", host_inst_rdy); end
      #2 rst_n = 1'b0;
      #1;
      vec_cnt++; if (inst_en !== 4'h0) begin err_cnt++; $display("FAIL mid_inst_en got %b want 0000", inst_en); end
      vec_cnt++; if (inst_data !== 56'h0) begin err_cnt++; $display("FAIL mid_inst_data got %h want 0", inst_data); end
      vec_cnt++; if (act_data_in !== 128'h0) begin err_cnt++; $display("FAIL mid_act_data got %h want 0", act_data_in); end
      vec_cnt++; if (act_data_in_vld !== 4'h0) begin err_cnt++; $display("FAIL mid_act_vld got %b want 0000", act_data_in_vld); end
      vec_cnt++; if (src_act_rdy !== 1'b0) begin err_cnt++; $display("FAIL mid_src_rdy got %b want 0", src_act_rdy); end
      vec_cnt++; if (host_inst_rdy !== 1'b1) begin err_cnt++; $display("FAIL mid_slot_cleared got %b want 1", host_inst_rdy); end
      act_data_in_req = 4'h0; src_act_vld = 1'b0; status_sblk = 4'h0;
      repeat (2) @(posedge clk_l);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         vec_cnt++; if (all_idle !== 1'b1) begin err_cnt++; $display("FAIL post_idle cyc %0d got %b want 1", i, all_idle); end
         vec_cnt++; if (inst_en !== 4'h0) begin err_cnt++; $display("FAIL post_inst_en cyc %0d got %b want 0000", i, inst_en); end
         vec_cnt++; if (act_data_in_vld !== 4'h0) begin err_cnt++; $display("FAIL post_act_vld cyc %0d got %b want 0000", i, act_data_in_vld); end
      end
   endtask

   initial begin
      test_reset();
      test_issue();
      test_guard();
      test_rr();
      test_req_drop();
      test_vld_toggle();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/sblk_row_sched.md
# sblk_row_sched

Scheduler in front of `sblk_row`. It accepts a single host instruction stream tagged with a target row and dispatches each instruction as an `inst_en` pulse to that row once the row's superblock is idle. It also shares one activation source stream among all rows' `act_data_in_req` requesters using round-robin bursts. It runs in the `clk_l` domain, between the top-level controller and `sblk_row`.

## Interface
- `N_ROW`, 4: number of superblock rows served.
- `WID_ROW`, 2: row-index width, equal to $clog2(N_ROW); N_ROW ≥ 2.
- `WID_ACT`, 16: activation element width; one beat is 2*WID_ACT bits.
- `WID_INST`, 14: instruction width; equals the sblk instruction word width.
- `BURST`, 8: maximum activation beats per grant; ≥ 1.
- `GUARD`, 2: cycles after an issue during which a row's `status_sblk` is ignored.

Ports:
- `clk_l`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `host_inst_data`  in  WID_INST  instruction word.
- `host_inst_row`  in  WID_ROW  target row.
- `host_inst_vld`  in  1  instruction valid.
- `host_inst_rdy`  out  1  instruction accepted when high with vld.
- `inst_data`  out  WID_INST*N_ROW  per-row instruction, slice r = [r*WID_INST +: WID_INST].
- `inst_en`  out  N_ROW  one-cycle issue pulse per row.
- `status_sblk`  in  N_ROW  1 = row busy.
- `src_act_data`  in  2*WID_ACT  activation beat from the source.
- `src_act_vld`  in  1  source beat valid.
- `src_act_rdy`  out  1  source beat consumed when high with vld.
- `act_data_in`  out  2*WID_ACT*N_ROW  per-row activation beat.
- `act_data_in_vld`  out  N_ROW  per-row beat valid, one cycle per beat.
- `act_data_in_req`  in  N_ROW  row requests activations.
- `all_idle`  out  1  scheduler and all rows quiescent.

## Operation
Instruction path:
- Each row has a 1-deep slot holding `full` and `data`.
- `host_inst_rdy` = ~full[host_inst_row]. This is combinational.
- On accept, `slot[row]` is written and full is set.
- Issue condition for row r: full[r] & ~status_sblk[r] & (guard_cnt[r]==0).
- On issue:
  - `inst_en[r]` is registered high for exactly 1 cycle.
  - `inst_data` slice r is loaded with the slot data and held until the next issue to r.
  - full[r] is cleared.
  - guard_cnt[r] is loaded with GUARD and decrements to 0.
- Rows are independent. Several rows may issue in the same cycle.
- The same-edge accept-while-issue case does not occur: rdy is low while full.

Activation arbiter, two states:
- IDLE:
  - If any act_data_in_req bit is high, pick the first requester at or after `ptr` in circular order.
  - Register the result as `g`, clear `cnt`, and go to GRANT.
  - `src_act_rdy` = 0.
- GRANT:
  - `src_act_rdy` = act_data_in_req[g].
  - A beat occurs when src_act_vld & src_act_rdy.
  - On a beat, slice g of `act_data_in` gets `src_act_data`, `act_data_in_vld[g]` is 1 on the next cycle, and cnt increments.
  - Exit to IDLE with ptr = (g+1) mod N_ROW when:
    - a beat occurs with cnt==BURST-1, or
    - act_data_in_req[g]==0.
- Non-granted slices of `act_data_in` hold their value.
- `act_data_in_vld` is one-hot or zero.

`all_idle` = no slot full & status_sblk==0 & all guard_cnt==0 & arbiter in IDLE. This is combinational.

Reset (asynchronous, any time):
- Slots emptied, guards 0, state IDLE, ptr 0.
- `inst_en`, `inst_data`, `act_data_in`, and `act_data_in_vld` are all 0.
- `src_act_rdy` = 0.
- Any in-flight beat or pending instruction is dropped.

## Timing
- Instruction accept edge at end of cycle T means `inst_en` is high in cycle T+2 at the earliest, given status low and guard 0.
- After an issue, the same row's next issue is no earlier than GUARD+1 cycles later, even if `status_sblk` is still low.
- Source beat in cycle T appears as `act_data_in_vld[g]` in cycle T+1.
- Grant latency: a request seen in IDLE in cycle T allows the first beat in cycle T+1.
- Each grant release costs 1 IDLE cycle.
- Full-rate streaming within a grant: 1 beat per cycle.
- Maximum run per grant is BURST beats. A requester waits at most (N_ROW-1)*(BURST+1) cycles.
- `status_sblk` rising after `inst_en` must occur within GUARD cycles. This is a system requirement, not checked here.

## Test plan
- Reset release, then an instruction 0x1A5 to row 2 with status 0:
  - host_inst_rdy=1 at the accept;
  - inst_en=4'b0100 exactly 2 cycles after the accept;
  - inst_data slice 2 = 0x1A5.
- Row 1 status held high, then two instructions to row 1:
  - the first is accepted;
  - rdy goes low for the second;
  - after status drops, inst_en[1] pulses;
  - the second is accepted and issues no earlier than GUARD+1 cycles after the first.
- All rows requesting, src_act_vld constant, BURST=8:
  - grants rotate 0,1,2,3,0;
  - each grant has 8 consecutive vld beats on the correct slice;
  - there is 1 gap cycle between grants.
- Row 0 requesting, req drops after 3 beats:
  - exactly 3 act_data_in_vld[0] pulses;
  - arbiter returns to IDLE;
  - ptr=1, so the next grant goes to a requesting row ≥1 first.
- src_act_vld toggling 1,0,1 in GRANT:
  - beats are counted only on handshakes;
  - data order is preserved;
  - no duplicated vld.
- Assert rst_n low mid-burst with a slot full:
  - all outputs go 0 immediately;
  - after release, all_idle=1 with no inst_en or act_data_in_vld until new stimulus.
